rc4_ksa_engine: RTL and testbench

Parametrised RC4 key-scheduling engine: optionally initialises the S-array to the identity permutation, then runs the KSA swap loop over an external single-port S-array RAM. It generalises the fixed 24-bit-key shuffler in key length, S-array size and RAM read latency, and adds an integrated init phase, a busy flag and an abort. It sits between the key-search controller and the S-array RAM, ahead of the PRGA/decrypt stage.

---
 rtl/rc4_pkg.sv | 32 +++
 rtl/rc4_ksa_engine_if.sv | 35 +++
 rtl/ksa_key_sel.sv | 41 ++++
 rtl/rc4_ksa_engine.sv | 166 ++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// Shared types, default sizes and the key-word helper for the RC4 key-scheduling engine.
package rc4_pkg;

    localparam int RC4_ADDR_W       = 8;
    localparam int RC4_KEY_LEN      = 3;
    // Widest key the helper can slice; callers zero-extend into this width.
    localparam int RC4_MAX_KEY_BITS = 256;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        WAIT_I,
        CALC_J,
        RD_J,
        WAIT_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

    // Key words are packed most-significant first; word idx lands in the low bits.
    function automatic logic [RC4_MAX_KEY_BITS-1:0] key_word(
        input logic [RC4_MAX_KEY_BITS-1:0] key,
        input int                          idx,
        input int                          word_w,
        input int                          key_len
    );
        return key >> ((key_len - 1 - idx) * word_w);
    endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Controller-side and RAM-side signals of the RC4 key-scheduling engine.
//
// Handshake: start is sampled only while busy=0; the edge that samples it
// latches secret_key and do_init and raises busy on the next cycle. The run
// ends with a single-cycle finish pulse (busy still 1), after which busy
// drops. abort cancels a run without a finish pulse. RAM reads return q
// READ_LAT cycles after the address cycle; write_enable marks write cycles.
interface rc4_ksa_engine_if
    import rc4_pkg::*;
#(
    parameter int ADDR_W  = RC4_ADDR_W,
    parameter int KEY_LEN = RC4_KEY_LEN
);
    logic                        start;
    logic                        do_init;
    logic                        abort;
    logic [KEY_LEN*ADDR_W-1:0]   secret_key;
    logic [ADDR_W-1:0]           q;
    logic [ADDR_W-1:0]           memory_address;
    logic [ADDR_W-1:0]           data;
    logic                        write_enable;
    logic                        busy;
    logic                        finish;
    ksa_state_t                  dbg_state;

    modport slave (
        input  start, do_init, abort, secret_key, q,
        output memory_address, data, write_enable, busy, finish, dbg_state
    );

    modport master (
        output start, do_init, abort, secret_key, q,
        input  memory_address, data, write_enable, busy, finish, dbg_state
    );
endinterface

// File: rtl/ksa_key_sel.sv
// Selects key[i mod KEY_LEN] using an index counter that wraps at KEY_LEN.
module ksa_key_sel
    import rc4_pkg::*;
#(
    parameter int ADDR_W  = RC4_ADDR_W,
    parameter int KEY_LEN = RC4_KEY_LEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      advance_i,
    input  logic [KEY_LEN*ADDR_W-1:0] key_i,
    output logic [ADDR_W-1:0]         word_o
);
    localparam int               IDX_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_LEN - 1);

    logic [IDX_W-1:0] idx_q, idx_d;

    // Next key index: cleared at run start, stepped with i, wrapping at KEY_LEN.
    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (advance_i) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Index register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign word_o = ADDR_W'(key_word(RC4_MAX_KEY_BITS'(key_i), int'(idx_q), ADDR_W, KEY_LEN));

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key scheduling over an external single-port S-array RAM, with an
// optional identity-init pass and a configurable RAM read latency.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int ADDR_W   = RC4_ADDR_W,
    parameter int KEY_LEN  = RC4_KEY_LEN,
    parameter int READ_LAT = 1
) (
    input logic              clk,
    input logic              reset,
    rc4_ksa_engine_if.slave  bus
);
    localparam int                WCNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(READ_LAT - 1);

    ksa_state_t                state_q, state_d;
    logic [ADDR_W-1:0]         i_q, i_d;
    logic [ADDR_W-1:0]         j_q, j_d;
    logic [ADDR_W-1:0]         si_q, si_d;
    logic [ADDR_W-1:0]         sj_q, sj_d;
    logic [WCNT_W-1:0]         wait_q, wait_d;
    logic [KEY_LEN*ADDR_W-1:0] key_q, key_d;
    logic [ADDR_W-1:0]         key_w;
    logic [ADDR_W-1:0]         addr_o, data_o;
    logic                      we_o;

    ksa_key_sel #(.ADDR_W(ADDR_W), .KEY_LEN(KEY_LEN)) u_key_sel (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == IDLE && bus.start),
        .advance_i (state_q == WR_J),
        .key_i     (key_q),
        .word_o    (key_w)
    );

    // Next state and datapath updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        wait_d  = wait_q;
        key_d   = key_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    key_d   = bus.secret_key;
                    i_d     = '0;
                    j_d     = '0;
                    wait_d  = '0;
                    state_d = bus.do_init ? INIT : RD_I;
                end
            end
            INIT: begin
                if (i_q == '1) begin
                    i_d     = '0;
                    state_d = RD_I;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            RD_I: begin
                wait_d  = '0;
                state_d = WAIT_I;
            end
            WAIT_I: begin
                if (wait_q == WAIT_LAST) begin
                    si_d    = bus.q;
                    wait_d  = '0;
                    state_d = CALC_J;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CALC_J: begin
                j_d     = j_q + si_q + key_w;
                state_d = RD_J;
            end
            RD_J: begin
                wait_d  = '0;
                state_d = WAIT_J;
            end
            WAIT_J: begin
                if (wait_q == WAIT_LAST) begin
                    sj_d    = bus.q;
                    wait_d  = '0;
                    state_d = WR_I;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WR_I: state_d = WR_J;
            WR_J: begin
                if (i_q == '1) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = RD_I;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            wait_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            wait_q  <= wait_d;
            key_q   <= key_d;
        end
    end

    // RAM port decode from registered state only; the address is held through each wait.
    always_comb begin
        addr_o = '0;
        data_o = '0;
        we_o   = 1'b0;
        case (state_q)
            INIT: begin
                addr_o = i_q;
                data_o = i_q;
                we_o   = 1'b1;
            end
            RD_I, WAIT_I: addr_o = i_q;
            RD_J, WAIT_J: addr_o = j_q;
            WR_I: begin
                addr_o = i_q;
                data_o = sj_q;
                we_o   = 1'b1;
            end
            WR_J: begin
                addr_o = j_q;
                data_o = si_q;
                we_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.memory_address = addr_o;
    assign bus.data           = data_o;
    assign bus.write_enable   = we_o;
    assign bus.busy           = (state_q != IDLE);
    assign bus.finish         = (state_q == DONE);
    assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: three instances (defaults, READ_LAT=3, 4-entry array)
// each with its own behavioural RAM, checked against a software KSA model.
module tb_rc4_ksa_engine;
    import rc4_pkg::*;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        do_init = 1'b0;
    logic        abort = 1'b0;
    logic        preload = 1'b0;
    logic [23:0] key = '0;
    int          sel = 0;

    int checks = 0;
    int errors = 0;

    rc4_ksa_engine_if #(.ADDR_W(8), .KEY_LEN(3)) ifa ();
    rc4_ksa_engine_if #(.ADDR_W(8), .KEY_LEN(3)) ifb ();
    rc4_ksa_engine_if #(.ADDR_W(2), .KEY_LEN(1)) ifc ();

    assign ifa.start      = start && (sel == 0);
    assign ifa.abort      = abort && (sel == 0);
    assign ifa.do_init    = do_init;
    assign ifa.secret_key = key;
    assign ifb.start      = start && (sel == 1);
    assign ifb.abort      = abort && (sel == 1);
    assign ifb.do_init    = do_init;
    assign ifb.secret_key = key;
    assign ifc.start      = start && (sel == 2);
    assign ifc.abort      = abort && (sel == 2);
    assign ifc.do_init    = do_init;
    assign ifc.secret_key = key[1:0];

    rc4_ksa_engine #(.ADDR_W(8), .KEY_LEN(3), .READ_LAT(1)) dut_a (.clk(clk), .reset(rst_n), .bus(ifa.slave));
    rc4_ksa_engine #(.ADDR_W(8), .KEY_LEN(3), .READ_LAT(3)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb.slave));
    rc4_ksa_engine #(.ADDR_W(2), .KEY_LEN(1), .READ_LAT(1)) dut_c (.clk(clk), .reset(rst_n), .bus(ifc.slave));

    // Behavioural RAMs: registered read pipeline of READ_LAT stages
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [1:0] mem_c [4];
    logic [7:0] rd_a;
    logic [7:0] rd_b [3];
    logic [1:0] rd_c;

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) begin
                mem_a[k] <= 8'(k);
                mem_b[k] <= 8'(k);
            end
            for (int k = 0; k < 4; k++) mem_c[k] <= 2'(k);
        end else begin
            if (ifa.write_enable) mem_a[ifa.memory_address] <= ifa.data;
            if (ifb.write_enable) mem_b[ifb.memory_address] <= ifb.data;
            if (ifc.write_enable) mem_c[ifc.memory_address] <= ifc.data;
        end
        rd_a     <= mem_a[ifa.memory_address];
        rd_b[0]  <= mem_b[ifb.memory_address];
        rd_b[1]  <= rd_b[0];
        rd_b[2]  <= rd_b[1];
        rd_c     <= mem_c[ifc.memory_address];
    end
    assign ifa.q = rd_a;
    assign ifb.q = rd_b[2];
    assign ifc.q = rd_c;

    // Monitored outputs of the instance under test
    logic fin_m, busy_m, we_m;
    always_comb begin
        fin_m  = ifc.finish;
        busy_m = ifc.busy;
        we_m   = ifc.write_enable;
        if (sel == 0) begin
            fin_m  = ifa.finish;
            busy_m = ifa.busy;
            we_m   = ifa.write_enable;
        end else if (sel == 1) begin
            fin_m  = ifb.finish;
            busy_m = ifb.busy;
            we_m   = ifb.write_enable;
        end
    end

    // Scoreboard: software KSA on a plain integer array
    int ms [256];

    task automatic model_identity();
        for (int k = 0; k < 256; k++) ms[k] = k;
    endtask

    task automatic model_ksa(input int n, input int kl, input int w, input logic [23:0] k);
        int j, t, kw;
        j = 0;
        for (int i = 0; i < n; i++) begin
            kw    = int'(k >> ((kl - 1 - (i % kl)) * w)) & (n - 1);
            j     = (j + ms[i] + kw) % n;
            t     = ms[i];
            ms[i] = ms[j];
            ms[j] = t;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_mem(input string tag, input int s, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            if (s == 0 && mem_a[k] !== 8'(ms[k])) bad++;
            if (s == 1 && mem_b[k] !== 8'(ms[k])) bad++;
            if (s == 2 && mem_c[k] !== 2'(ms[k])) bad++;
        end
        check(tag, 64'(bad), 64'(0));
    endtask

    // Driver tasks
    task automatic preload_identity();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic start_run(input int s, input logic init, input logic [23:0] k);
        @(negedge clk);
        sel     = s;
        do_init = init;
        key     = k;
        start   = 1'b1;
    endtask

    // Counts cycles from cycle 0 until finish; fin_cyc stays -1 if the budget runs out.
    task automatic run_wait(input int budget, input logic hold, input int chg_cyc,
                            input logic [23:0] chg_key, input int pulse_cyc,
                            output int fin_cyc, output int we_cnt);
        fin_cyc = -1;
        we_cnt  = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) start = 1'b0;
            if (c == chg_cyc) key = chg_key;
            if (c == pulse_cyc) start = 1'b1;
            if (c == pulse_cyc + 1) start = 1'b0;
            if (we_m) we_cnt++;
            if (fin_m) begin
                fin_cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int fc, wc, fa, wa, ba;
        logic [23:0] k1, k2, kj;
        logic [1:0] tiny_exp [4];
        tiny_exp = '{2'd0, 2'd2, 2'd3, 2'd1};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs_a", 64'({ifa.busy, ifa.finish, ifa.write_enable, ifa.memory_address, ifa.data}), 64'(0));
        check("reset_outputs_c", 64'({ifc.busy, ifc.finish, ifc.write_enable, ifc.memory_address, ifc.data}), 64'(0));
        rst_n = 1'b1;

        // Tiny array, key 0, with init
        start_run(2, 1'b1, 24'h0);
        run_wait(200, 1'b0, -5, 24'h0, -5, fc, wc);
        check("tiny_finish_cycle", 64'(fc), 64'(32));
        check("tiny_busy_in_done", 64'(busy_m), 64'(1));
        for (int k = 0; k < 4; k++) check($sformatf("tiny_s%0d", k), 64'(mem_c[k]), 64'(tiny_exp[k]));
        @(negedge clk);
        check("tiny_busy_after_finish", 64'(busy_m), 64'(0));

        // Defaults with init, key 000249
        start_run(0, 1'b1, 24'h000249);
        run_wait(4000, 1'b0, -5, 24'h0, -5, fc, wc);
        check("default_finish_cycle", 64'(fc), 64'(2048));
        check("default_write_strobes", 64'(wc), 64'(768));
        model_identity();
        model_ksa(256, 3, 8, 24'h000249);
        cmp_mem("default_ram", 0, 256);
        @(negedge clk);
        check("default_finish_one_cycle", 64'({busy_m, fin_m}), 64'(0));

        // Random key, no init, identity preloaded
        preload_identity();
        k1 = 24'($urandom);
        start_run(0, 1'b0, k1);
        run_wait(4000, 1'b0, -5, 24'h0, -5, fc, wc);
        check("noinit_finish_cycle", 64'(fc), 64'(1792));
        model_identity();
        model_ksa(256, 3, 8, k1);
        cmp_mem("noinit_ram", 0, 256);

        // READ_LAT=3, no init, same key
        preload_identity();
        start_run(1, 1'b0, k1);
        run_wait(4000, 1'b0, -5, 24'h0, -5, fc, wc);
        check("lat3_finish_cycle", 64'(fc), 64'(2816));
        cmp_mem("lat3_ram", 1, 256);

        // Abort at cycle 100, then a clean run
        k1 = 24'($urandom);
        start_run(0, 1'b1, k1);
        fa = 0;
        wa = 0;
        for (int c = 0; c <= 400; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == 100) abort = 1'b1;
            if (c == 101) begin
                abort = 1'b0;
                check("abort_idle_next_cycle", 64'(busy_m), 64'(0));
            end
            if (c >= 101 && we_m) wa++;
            if (fin_m) fa++;
        end
        check("abort_no_writes", 64'(wa), 64'(0));
        check("abort_no_finish", 64'(fa), 64'(0));
        k2 = 24'($urandom);
        start_run(0, 1'b1, k2);
        run_wait(4000, 1'b0, -5, 24'h0, -5, fc, wc);
        check("after_abort_finish_cycle", 64'(fc), 64'(2048));
        model_identity();
        model_ksa(256, 3, 8, k2);
        cmp_mem("after_abort_ram", 0, 256);

        // Asynchronous reset in WAIT_J of iteration 10 (cycle 4 + 7*10)
        preload_identity();
        start_run(0, 1'b0, 24'($urandom));
        for (int c = 0; c <= 74; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
        end
        check("reset_taken_in_wait_j", 64'(ifa.dbg_state), 64'(WAIT_J));
        #1 rst_n = 1'b0;
        #1 check("reset_async_outputs", 64'({ifa.busy, ifa.finish, ifa.write_enable, ifa.memory_address, ifa.data}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        fa = 0;
        ba = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (fin_m) fa++;
            if (busy_m) ba++;
        end
        check("reset_no_finish_or_busy", 64'({fa[15:0], ba[15:0]}), 64'(0));

        // start held high, key changed at cycle 10, back-to-back second run
        k1 = 24'($urandom);
        k2 = k1 ^ (24'($urandom) | 24'h1);
        kj = ~k2;
        start_run(0, 1'b1, k1);
        run_wait(4000, 1'b1, 10, k2, -5, fc, wc);
        check("hold_finish_cycle", 64'(fc), 64'(2048));
        model_identity();
        model_ksa(256, 3, 8, k1);
        cmp_mem("hold_ram_original_key", 0, 256);
        @(negedge clk);
        check("hold_idle_gap", 64'(busy_m), 64'(0));
        @(negedge clk);
        check("hold_restart_busy", 64'(busy_m), 64'(1));
        start = 1'b0;
        // A start pulse with a different key mid-run must be ignored
        run_wait(4000, 1'b1, 500, kj, 500, fc, wc);
        check("second_run_finish_cycle", 64'(fc), 64'(2047));
        model_identity();
        model_ksa(256, 3, 8, k2);
        cmp_mem("second_run_ram", 0, 256);
        @(negedge clk);
        check("no_run_from_busy_pulse", 64'(busy_m), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
